// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for serial_add_sub; o_overflow exists only when
// SERIAL_ADDSUB_OVF_EN is defined.
interface serial_add_sub_if #(
  parameter int WIDTH = 4
);
  logic             i_start;
  logic             i_mode;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_carry;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             o_overflow;
`endif

  modport master (
    output i_start, i_mode, i_a, i_b,
    input  o_busy, o_done, o_result, o_carry
`ifdef SERIAL_ADDSUB_OVF_EN
    , input o_overflow
`endif
  );

  modport slave (
    input  i_start, i_mode, i_a, i_b,
    output o_busy, o_done, o_result, o_carry
`ifdef SERIAL_ADDSUB_OVF_EN
    , output o_overflow
`endif
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice plus carry flop, LSB first.
// Optional signed-overflow output enabled by SERIAL_ADDSUB_OVF_EN.
module serial_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  serial_add_sub_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_maj;
  logic             w_last;

  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_maj  = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
      r_carry      <= 1'b0;
      r_cnt        <= '0;
      bus.o_busy   <= 1'b0;
      bus.o_done   <= 1'b0;
      bus.o_result <= '0;
      bus.o_carry  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      bus.o_overflow <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          bus.o_done <= 1'b0;
          if (bus.i_start) begin
            r_a        <= bus.i_a;
            r_b        <= bus.i_mode ? ~bus.i_b : bus.i_b;
            r_carry    <= bus.i_mode;
            r_sum      <= '0;
            r_cnt      <= '0;
            bus.o_busy <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_maj;
          r_cnt   <= r_cnt + 1'b1;
          // Results are taken from the next-state values so they land on the
          // same edge the final bit is produced.
          if (w_last) begin
            bus.o_result <= {w_s, r_sum[WIDTH-1:1]};
            bus.o_carry  <= w_maj;
`ifdef SERIAL_ADDSUB_OVF_EN
            bus.o_overflow <= r_carry ^ w_maj;
`endif
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          bus.o_busy <= 1'b0;
          bus.o_done <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub (WIDTH=4): vector table plus handshake,
// back-to-back start and mid-operation reset sequences.
module tb_serial_add_sub;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(W)) bus ();
  serial_add_sub #(.WIDTH(W)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       m;
    logic [3:0] r;
    logic       c;
    logic       v;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic m);
    logic [3:0] r;
    logic       c;
    logic       v;
    if (m) begin
      r = a - b;
      c = (a >= b);
      v = (a[3] != b[3]) && (r[3] != a[3]);
    end else begin
      r = a + b;
      c = ({1'b0, a} + {1'b0, b}) > 5'd15;
      v = (a[3] == b[3]) && (r[3] != a[3]);
    end
    return {v, c, r};
  endfunction

  // Launches one operation and waits for o_done; lat = cycles after accept edge.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic m, output int lat);
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_a = a; bus.i_b = b; bus.i_mode = m;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    chk("busy_after_accept", bus.o_busy, 1);
    lat = -1;
    for (int j = 0; j < 20; j++) begin
      if (bus.o_done) begin
        lat = j;
        chk("busy_low_at_done", bus.o_busy, 0);
        break;
      end
      @(posedge clk); #1;
    end
    chk("done_latency", lat, W + 1);
    @(posedge clk); #1;
    chk("done_one_cycle", bus.o_done, 0);
  endtask

  initial begin
    int lat;
    int ndone;
    logic [3:0] ha[20];
    logic [3:0] hb[20];
    logic       hm[20];
    logic [5:0] e;

    vecs[0]  = '{4'd5,  4'd3, 1'b0, 4'd8,  1'b0, 1'b1};
    vecs[1]  = '{4'd9,  4'd9, 1'b0, 4'd2,  1'b1, 1'b1};
    vecs[2]  = '{4'd3,  4'd5, 1'b1, 4'd14, 1'b0, 1'b0};
    vecs[3]  = '{4'd7,  4'd7, 1'b1, 4'd0,  1'b1, 1'b0};
    vecs[4]  = '{4'd8,  4'd1, 1'b1, 4'd7,  1'b1, 1'b1};
    vecs[5]  = '{4'd0,  4'd0, 1'b0, 4'd0,  1'b0, 1'b0};
    vecs[6]  = '{4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0};
    vecs[7]  = '{4'd6,  4'd2, 1'b1, 4'd4,  1'b1, 1'b0};
    vecs[8]  = '{4'd0,  4'd1, 1'b1, 4'd15, 1'b0, 1'b0};
    vecs[9]  = '{4'd7,  4'd1, 1'b0, 4'd8,  1'b0, 1'b1};
    vecs[10] = '{4'd2,  4'd8, 1'b1, 4'd10, 1'b0, 1'b1};

    bus.i_start = 1'b0; bus.i_mode = 1'b0; bus.i_a = '0; bus.i_b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_result", bus.o_result, 0);
    chk("rst_carry", bus.o_carry, 0);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("rst_ovf", bus.o_overflow, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, lat);
      chk($sformatf("vec%0d_result", i), bus.o_result, vecs[i].r);
      chk($sformatf("vec%0d_carry", i), bus.o_carry, vecs[i].c);
`ifdef SERIAL_ADDSUB_OVF_EN
      chk($sformatf("vec%0d_ovf", i), bus.o_overflow, vecs[i].v);
`endif
    end

    // Result must hold across idle cycles.
    repeat (4) @(posedge clk);
    #1;
    chk("hold_result", bus.o_result, vecs[10].r);

    // i_start held high with operands changing every cycle.
    for (int c = 0; c < 20; c++) begin
      ha[c] = 4'(3 * c + 1);
      hb[c] = 4'(5 * c + 2);
      hm[c] = 1'((c / 6) & 1);
    end
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_a = ha[0]; bus.i_b = hb[0]; bus.i_mode = hm[0];
    ndone = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (bus.o_done) ndone++;
      chk($sformatf("cont_done_j%0d", j), bus.o_done, (j == 5 || j == 11 || j == 17));
      if (j == 5 || j == 11 || j == 17) begin
        e = model(ha[j-5], hb[j-5], hm[j-5]);
        chk($sformatf("cont_result_j%0d", j), bus.o_result, e[3:0]);
        chk($sformatf("cont_carry_j%0d", j), bus.o_carry, e[4]);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk($sformatf("cont_ovf_j%0d", j), bus.o_overflow, e[5]);
`endif
      end
      if (j < 19) begin
        bus.i_a = ha[j+1]; bus.i_b = hb[j+1]; bus.i_mode = hm[j+1];
      end
    end
    chk("cont_done_count", ndone, 3);
    bus.i_start = 1'b0;
    repeat (10) @(posedge clk);

    // Reset two cycles into SHIFT aborts the operation.
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_a = 4'd9; bus.i_b = 4'd4; bus.i_mode = 1'b0;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", bus.o_busy, 0);
    chk("abort_done", bus.o_done, 0);
    chk("abort_result", bus.o_result, 0);
    chk("abort_carry", bus.o_carry, 0);
    ndone = 0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      if (bus.o_done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op(4'd9, 4'd4, 1'b0, lat);
    chk("after_abort_result", bus.o_result, 13);
    chk("after_abort_carry", bus.o_carry, 0);

    // Reset and start on the same edge: reset wins.
    @(posedge clk); #1;
    rst = 1'b1; bus.i_start = 1'b1; bus.i_a = 4'd5; bus.i_b = 4'd3; bus.i_mode = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; bus.i_start = 1'b0;
    chk("rst_start_busy", bus.o_busy, 0);
    @(posedge clk); #1;
    chk("rst_start_not_started", bus.o_busy, 0);
    chk("rst_start_result", bus.o_result, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial adder/subtractor: it accepts two WIDTH-bit operands and a mode bit through a start/done handshake, then produces the sum or difference LSB-first over WIDTH clock cycles using a single full-adder slice plus a carry flip-flop. It is the sequential, area-minimal counterpart to the parallel ripple adder. It serves datapaths that trade latency for logic, and it is the bench target for add/subtract correctness in the adder_subtractor project.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- i_clk  input  1  rising-edge clock.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  request; sampled only in IDLE.
- i_mode  input  1  0 = add (A+B), 1 = subtract (A-B); sampled with i_start.
- i_a  input  WIDTH  operand A; sampled with i_start.
- i_b  input  WIDTH  operand B; sampled with i_start.
- o_busy  output  1  high while in SHIFT.
- o_done  output  1  one-cycle pulse marking result valid.
- o_result  output  WIDTH  sum or difference, held between operations.
- o_carry  output  1  final carry-out; in subtract mode 1 = no borrow, 0 = borrow.
- o_overflow  output  1  signed overflow; present only with SERIAL_ADDSUB_OVF_EN.

## Operation
- States: IDLE, SHIFT, DONE. Reset enters IDLE.
- IDLE, i_start=1: latch a_reg=i_a, and b_reg=i_b (i_mode=0) or ~i_b (i_mode=1). Set carry_ff=i_mode, clear bit counter to 0, go to SHIFT.
- IDLE, i_start=0: stay in IDLE. All outputs hold.
- SHIFT, each cycle:
  - s = a_reg[0]^b_reg[0]^carry_ff; carry_ff <= majority(a_reg[0], b_reg[0], carry_ff).
  - a_reg and b_reg shift right by one; the sum shift register shifts right with s inserted at the MSB.
  - Counter increments.
  - When the counter reaches WIDTH-1, go to DONE.
- Entering DONE: o_result <= final sum register and o_carry <= final carry_ff, both loaded on the same edge.
- DONE: o_done=1 for exactly one cycle, then go to IDLE unconditionally.
- i_start outside IDLE is ignored. It is not queued.
- i_mode, i_a and i_b changing during SHIFT have no effect.
- o_result, o_carry and o_overflow change only on entry to DONE or on reset.
- Arithmetic is modulo 2^WIDTH. Subtract is two's complement: A + ~B + 1.

## Timing
- Reset values: o_busy=0, o_done=0, o_result=0, o_carry=0, o_overflow=0. Internal registers and counter are cleared.
- i_start sampled high at edge k → o_busy=1 from edge k through edge k+WIDTH.
- At edge k+WIDTH+1: o_busy=0, o_done=1, and the result is valid.
- o_done falls at edge k+WIDTH+2, when the block is back in IDLE.
- Earliest next accepted i_start is at edge k+WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- Reset during SHIFT or DONE: the operation is aborted, no o_done pulse is produced, and all outputs take their reset values on that edge.
- Reset and i_start high on the same edge: reset wins.

## Configuration
- Macro: SERIAL_ADDSUB_OVF_EN.
- Defined:
  - The o_overflow port exists.
  - The carry into the MSB position is captured during the last SHIFT cycle.
  - o_overflow <= carry_into_msb ^ carry_out, loaded on entry to DONE.
- Undefined:
  - The o_overflow port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Add with signed overflow, WIDTH=4: i_a=5, i_b=3, i_mode=0 → o_result=8, o_carry=0, o_overflow=1. o_done pulses exactly at start edge+5.
- Add with carry-out: i_a=9, i_b=9, i_mode=0 → o_result=2, o_carry=1, o_overflow=1.
- Subtract with borrow: i_a=3, i_b=5, i_mode=1 → o_result=14 (i.e. -2), o_carry=0, o_overflow=0.
- Subtract, equal operands: i_a=7, i_b=7, i_mode=1 → o_result=0, o_carry=1. Then i_a=8, i_b=1, i_mode=1 → o_result=7, o_overflow=1.
- i_start held high continuously with changing operands: only one operation is accepted per WIDTH+2 cycles. Each result matches the operands sampled at acceptance. Exactly one o_done pulse per operation.
- Reset mid-operation: assert i_reset two cycles into SHIFT. Required: no o_done, outputs at 0 on the reset edge, and the next start completes correctly.
